banner_scroll_ctrl: RTL and testbench

BANNER_SCROLL_CTRL -- requirements
Module: banner_scroll_ctrl

---
 rtl/banner_scroll_ctrl_if.sv | 29 ++
 rtl/banner_scroll_ctrl.sv | 135 +++++++++++++
 tb/tb_banner_scroll_ctrl.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/banner_scroll_ctrl_if.sv
// Bus bundle for the banner scroll controller: control levels, tick,
// message-buffer write port and the display/status outputs.
interface banner_scroll_ctrl_if;
    logic        tick;
    logic        start;
    logic        stop;
    logic        pause;
    logic        dir;
    logic [4:0]  len;
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [3:0]  wr_data;
    logic [15:0] window;
    logic [3:0]  pos;
    logic        busy;
    logic        wrap;

    // Driver side (tick generator / host)
    modport master (
        output tick, start, stop, pause, dir, len, wr_en, wr_addr, wr_data,
        input  window, pos, busy, wrap
    );

    // Controller side
    modport slave (
        input  tick, start, stop, pause, dir, len, wr_en, wr_addr, wr_data,
        output window, pos, busy, wrap
    );
endinterface

// File: rtl/banner_scroll_ctrl.sv
// Banner scroll controller: 16-entry hex-digit message buffer scrolled through
// a four-digit window, one step every STEP_TICKS ticks, with pause/stop control.
module banner_scroll_ctrl #(
    parameter int STEP_TICKS = 8,
    parameter int MSG_DEPTH  = 16
) (
    input  logic                clk,
    input  logic                reset,
    banner_scroll_ctrl_if.slave bus
);

    typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;

    localparam logic [7:0] CNT_LAST = 8'(STEP_TICKS - 1);

    state_t      state_q, state_d;
    logic [3:0]  pos_q, pos_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [4:0]  len_q, len_d;
    logic        wrap_q, wrap_d;
    logic [15:0] window_q, window_d;
    logic [3:0]  buf_q [MSG_DEPTH];
    logic        busy;
    logic        len_ok;

    assign len_ok = (bus.len != 5'd0) && (bus.len <= 5'd16);

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic; stop overrides everything else
    always_comb begin
        state_d = state_q;
        if (bus.stop) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (bus.start && len_ok) state_d = RUN;
                RUN:     if (bus.pause)           state_d = HOLD;
                HOLD:    if (!bus.pause)          state_d = RUN;
                default:                          state_d = IDLE;
            endcase
        end
    end

    // Output logic
    always_comb begin
        busy = (state_q == RUN) || (state_q == HOLD);
    end

    // Position / step counter / length next-state; ticks only count in RUN
    always_comb begin
        pos_d  = pos_q;
        cnt_d  = cnt_q;
        len_d  = len_q;
        wrap_d = 1'b0;
        if (!bus.stop) begin
            if (state_q == IDLE && bus.start && len_ok) begin
                pos_d = 4'd0;
                cnt_d = 8'd0;
                len_d = bus.len;
            end else if (state_q == RUN && bus.tick) begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d = 8'd0;
                    if (!bus.dir) begin
                        if ({1'b0, pos_q} == len_q - 5'd1) begin
                            pos_d  = 4'd0;
                            wrap_d = 1'b1;
                        end else begin
                            pos_d = pos_q + 4'd1;
                        end
                    end else begin
                        if (pos_q == 4'd0) begin
                            pos_d  = 4'(len_q - 5'd1);
                            wrap_d = 1'b1;
                        end else begin
                            pos_d = pos_q - 4'd1;
                        end
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
        end
    end

    // Window contents: walk the message from pos, wrapping at len_q (pos < len_q always holds)
    always_comb begin
        logic [4:0] idx;
        logic [4:0] nxt;
        idx      = {1'b0, pos_q};
        nxt      = 5'd0;
        window_d = 16'h0000;
        for (int k = 3; k >= 0; k--) begin
            window_d[k*4 +: 4] = buf_q[idx[3:0]];
            nxt                = idx + 5'd1;
            idx                = (nxt == len_q) ? 5'd0 : nxt;
        end
    end

    // Scroll state and registered display
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pos_q    <= 4'd0;
            cnt_q    <= 8'd0;
            len_q    <= 5'd1;
            wrap_q   <= 1'b0;
            window_q <= 16'h0000;
        end else begin
            pos_q    <= pos_d;
            cnt_q    <= cnt_d;
            len_q    <= len_d;
            wrap_q   <= wrap_d;
            window_q <= window_d;
        end
    end

    // Message buffer, writable in any state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < MSG_DEPTH; i++) buf_q[i] <= 4'h0;
        end else if (bus.wr_en) begin
            buf_q[bus.wr_addr] <= bus.wr_data;
        end
    end

    assign bus.window = window_q;
    assign bus.pos    = pos_q;
    assign bus.busy   = busy;
    assign bus.wrap   = wrap_q;

endmodule

// File: tb/tb_banner_scroll_ctrl.sv
// Testbench for banner_scroll_ctrl: directed scenarios followed by a random
// phase, all compared against a behavioural model of the scrolling banner.
module tb_banner_scroll_ctrl;

    localparam int STEP = 8;

    logic clk = 1'b0;
    logic reset = 1'b0;

    banner_scroll_ctrl_if bif();

    banner_scroll_ctrl #(.STEP_TICKS(STEP), .MSG_DEPTH(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bif)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // Behavioural model: is the banner scrolling, is it frozen, where is it
    bit          m_active;
    bit          m_frozen;
    int          m_pos;
    int          m_ticks;
    int          m_len;
    logic [3:0]  m_mem [16];
    logic [15:0] e_window;
    logic        e_wrap;

    function automatic logic [15:0] view();
        logic [15:0] w;
        w = 16'h0000;
        for (int k = 0; k < 4; k++) w[4*k +: 4] = m_mem[(m_pos + 3 - k) % m_len];
        return w;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_active = 1'b0;
        m_frozen = 1'b0;
        m_pos    = 0;
        m_ticks  = 0;
        m_len    = 1;
        for (int i = 0; i < 16; i++) m_mem[i] = 4'h0;
        e_window = 16'h0000;
        e_wrap   = 1'b0;
    endtask

    // Advance the model by one clock edge using the inputs presented to it
    task automatic model_edge();
        logic [15:0] shown;
        shown  = view();
        e_wrap = 1'b0;
        if (bif.wr_en) m_mem[bif.wr_addr] = bif.wr_data;
        if (bif.stop) begin
            m_active = 1'b0;
            m_frozen = 1'b0;
        end else if (!m_active) begin
            if (bif.start && bif.len >= 5'd1 && bif.len <= 5'd16) begin
                m_active = 1'b1;
                m_frozen = 1'b0;
                m_pos    = 0;
                m_ticks  = 0;
                m_len    = int'(bif.len);
            end
        end else if (m_frozen) begin
            if (!bif.pause) m_frozen = 1'b0;
        end else begin
            if (bif.tick) begin
                m_ticks++;
                if (m_ticks == STEP) begin
                    m_ticks = 0;
                    if (!bif.dir) begin
                        m_pos  = (m_pos + 1) % m_len;
                        e_wrap = (m_pos == 0);
                    end else begin
                        e_wrap = (m_pos == 0);
                        m_pos  = (m_pos + m_len - 1) % m_len;
                    end
                end
            end
            if (bif.pause) m_frozen = 1'b1;
        end
        e_window = shown;
    endtask

    task automatic check_outputs();
        chk("pos",    32'(bif.pos),    32'(m_pos));
        chk("busy",   32'(bif.busy),   32'(m_active));
        chk("wrap",   32'(bif.wrap),   32'(e_wrap));
        chk("window", 32'(bif.window), 32'(e_window));
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
        check_outputs();
    endtask

    initial begin
        int nwrap;
        bif.tick = 1'b0; bif.start = 1'b0; bif.stop = 1'b0; bif.pause = 1'b0;
        bif.dir = 1'b0; bif.len = 5'd0; bif.wr_en = 1'b0;
        bif.wr_addr = 4'd0; bif.wr_data = 4'd0;

        // Reset state
        #2 reset = 1'b1;
        #1;
        model_reset();
        check_outputs();
        @(negedge clk);
        reset = 1'b0;

        // Forward scroll: buf = 0..7, len 8
        for (int i = 0; i < 8; i++) begin
            bif.wr_en = 1'b1; bif.wr_addr = 4'(i); bif.wr_data = 4'(i);
            cycle();
        end
        bif.wr_en = 1'b0;
        bif.len = 5'd8; bif.start = 1'b1;
        cycle();
        bif.start = 1'b0;
        chk("start_busy", 32'(bif.busy), 32'd1);
        bif.dir = 1'b0; bif.tick = 1'b1;
        repeat (8) cycle();
        chk("fwd_pos", 32'(bif.pos), 32'd1);
        bif.tick = 1'b0;
        cycle();
        chk("fwd_win", 32'(bif.window), 32'h1234);
        nwrap = 0;
        bif.tick = 1'b1;
        repeat (56) begin
            cycle();
            if (bif.wrap) nwrap++;
        end
        bif.tick = 1'b0;
        cycle();
        if (bif.wrap) nwrap++;
        chk("fwd_wrapcnt", 32'(nwrap), 32'd1);
        chk("fwd_pos0", 32'(bif.pos), 32'd0);

        // Backward scroll from pos 0
        bif.dir = 1'b1; bif.tick = 1'b1;
        repeat (8) cycle();
        chk("bwd_pos", 32'(bif.pos), 32'd7);
        chk("bwd_wrap", 32'(bif.wrap), 32'd1);
        bif.tick = 1'b0;
        cycle();
        chk("bwd_wrap_clr", 32'(bif.wrap), 32'd0);
        chk("bwd_win", 32'(bif.window), 32'h7012);

        // Pause in the middle of a step
        bif.stop = 1'b1; cycle(); bif.stop = 1'b0;
        bif.start = 1'b1; bif.len = 5'd8; bif.dir = 1'b0; cycle(); bif.start = 1'b0;
        bif.tick = 1'b1; repeat (5) cycle();
        bif.tick = 1'b0; bif.pause = 1'b1; cycle();
        bif.tick = 1'b1; repeat (20) cycle();
        chk("pause_hold_pos", 32'(bif.pos), 32'd0);
        bif.tick = 1'b0; bif.pause = 1'b0; cycle();
        bif.tick = 1'b1; repeat (3) cycle();
        bif.tick = 1'b0; cycle();
        chk("pause_pos", 32'(bif.pos), 32'd1);
        chk("pause_busy", 32'(bif.busy), 32'd1);

        // Stop beats start and the step-completing tick
        bif.tick = 1'b1; repeat (7) cycle();
        bif.stop = 1'b1; bif.start = 1'b1; cycle();
        chk("prio_busy", 32'(bif.busy), 32'd0);
        chk("prio_pos", 32'(bif.pos), 32'd1);
        bif.stop = 1'b0; bif.start = 1'b0; bif.tick = 1'b0; cycle();
        chk("prio_idle", 32'(bif.busy), 32'd0);

        // Short message repeats across the window
        bif.wr_en = 1'b1;
        bif.wr_addr = 4'd0; bif.wr_data = 4'hA; cycle();
        bif.wr_addr = 4'd1; bif.wr_data = 4'hB; cycle();
        bif.wr_addr = 4'd2; bif.wr_data = 4'hC; cycle();
        bif.wr_en = 1'b0;
        bif.len = 5'd3; bif.start = 1'b1; cycle(); bif.start = 1'b0;
        cycle();
        chk("short_win", 32'(bif.window), 32'hABCA);
        bif.stop = 1'b1; cycle(); bif.stop = 1'b0;
        bif.len = 5'd0; bif.start = 1'b1; cycle();
        chk("len0_busy", 32'(bif.busy), 32'd0);
        bif.len = 5'd17; cycle();
        chk("len17_busy", 32'(bif.busy), 32'd0);
        bif.start = 1'b0;

        // Single-character message wraps on every step
        bif.len = 5'd1; bif.start = 1'b1; cycle(); bif.start = 1'b0;
        nwrap = 0;
        bif.tick = 1'b1;
        repeat (16) begin
            cycle();
            if (bif.wrap) nwrap++;
        end
        bif.tick = 1'b0;
        chk("len1_wraps", 32'(nwrap), 32'd2);
        chk("len1_pos", 32'(bif.pos), 32'd0);

        // Random traffic
        repeat (1500) begin
            bif.tick    = ($urandom_range(0, 1) == 0);
            bif.start   = ($urandom_range(0, 5) == 0);
            bif.stop    = ($urandom_range(0, 49) == 0);
            if ($urandom_range(0, 15) == 0) bif.pause = ~bif.pause;
            bif.dir     = ($urandom_range(0, 3) == 0);
            bif.len     = 5'($urandom_range(0, 18));
            bif.wr_en   = ($urandom_range(0, 3) == 0);
            bif.wr_addr = 4'($urandom_range(0, 15));
            bif.wr_data = 4'($urandom_range(0, 15));
            cycle();
        end

        // Reset in the middle of scrolling
        bif.tick = 1'b0; bif.start = 1'b0; bif.pause = 1'b0; bif.wr_en = 1'b0;
        bif.dir = 1'b0;
        bif.stop = 1'b1; cycle(); bif.stop = 1'b0;
        bif.len = 5'd5; bif.start = 1'b1; cycle(); bif.start = 1'b0;
        bif.tick = 1'b1; repeat (10) cycle(); bif.tick = 1'b0;
        chk("pre_rst_busy", 32'(bif.busy), 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("rst_busy", 32'(bif.busy), 32'd0);
        chk("rst_window", 32'(bif.window), 32'h0000);
        chk("rst_pos", 32'(bif.pos), 32'd0);
        chk("rst_wrap", 32'(bif.wrap), 32'd0);
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        bif.len = 5'd4; bif.start = 1'b1; cycle(); bif.start = 1'b0;
        chk("restart_busy", 32'(bif.busy), 32'd1);
        bif.tick = 1'b1; repeat (8) cycle(); bif.tick = 1'b0;
        chk("restart_pos", 32'(bif.pos), 32'd1);
        cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
